// File: rtl/oled_axil_pkg.sv
// Shared constants and types for the OLED AXI4-Lite register slave.
// Build option: define SLVERR_EN to answer unmapped/illegal accesses with SLVERR.
package oled_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEF_NUM_REGS   = 4;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int STATUS_IDX     = DEF_NUM_REGS;

    typedef logic [DEF_ADDR_WIDTH-3:0] word_idx_t;

    // Response for writes to the status word and for any undecoded index.
    function automatic logic [1:0] miss_resp();
`ifdef SLVERR_EN
        return RESP_SLVERR;
`else
        return RESP_OKAY;
`endif
    endfunction

endpackage

// File: rtl/oled_axil_wr_merge.sv
// Byte-lane merge of AXI write data into an existing 32-bit register word.
module oled_axil_wr_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  strb,
    output logic [31:0] merged
);

    for (genvar b = 0; b < 4; b++) begin : g_lane
        assign merged[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old_word[8*b +: 8];
    end

endmodule

// File: rtl/oled_axil_slave_regs.sv
// AXI4-Lite register file for the OLED RGB controller: NUM_REGS RW words plus a status word.
// Build option: SLVERR_EN selects SLVERR (instead of OKAY) for undecoded/status-write accesses.
module oled_axil_slave_regs
    import oled_axil_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int          NUM_REGS   = DEF_NUM_REGS,
    parameter logic [31:0] RESET_VAL  = '0
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR,
    input  logic [2:0]             S_AXI_AWPROT,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [31:0]            S_AXI_WDATA,
    input  logic [3:0]             S_AXI_WSTRB,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR,
    input  logic [2:0]             S_AXI_ARPROT,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [31:0]            S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0] reg_out,
    output logic [NUM_REGS-1:0]    reg_wr_pulse,
    input  logic [31:0]            hw_status
);

    localparam int            IW       = ADDR_WIDTH - 2;
    localparam logic [IW-1:0] STAT_IDX = IW'(NUM_REGS);

    if (DATA_WIDTH != 32 || (2 ** IW) < NUM_REGS + 1) begin : g_param_check
        $error("oled_axil_slave_regs: DATA_WIDTH must be 32 and the address space must hold NUM_REGS+1 words");
    end

    logic [31:0]         regs [NUM_REGS];
    logic                aw_held, w_held;
    logic [IW-1:0]       aw_idx;
    logic [31:0]         w_data;
    logic [3:0]          w_strb;
    logic                bvalid, rvalid;
    logic [1:0]          bresp, rresp;
    logic [31:0]         rdata;
    logic [NUM_REGS-1:0] pulse;

    logic                aw_fire, w_fire, ar_fire, commit, wr_hit;
    logic [IW-1:0]       wr_idx, rd_idx;
    logic [31:0]         wr_data, wr_old, wr_new, rd_word;
    logic [3:0]          wr_strb;
    logic [1:0]          rd_resp;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = !ARESET && !aw_held && !bvalid;
    assign S_AXI_WREADY  = !ARESET && !w_held && !bvalid;
    assign S_AXI_ARREADY = !ARESET && !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign reg_wr_pulse  = pulse;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;

    // A held half and a same-cycle arriving half are treated identically.
    assign wr_idx  = aw_held ? aw_idx : S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign wr_data = w_held ? w_data : S_AXI_WDATA;
    assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;
    assign commit  = (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_hit  = wr_idx < STAT_IDX;
    assign rd_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:2];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign reg_out[32*k +: 32] = regs[k];
    end

    always_comb begin
        wr_old = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_idx == IW'(k)) wr_old = regs[k];
        end
    end

    oled_axil_wr_merge u_merge (
        .old_word (wr_old),
        .wdata    (wr_data),
        .strb     (wr_strb),
        .merged   (wr_new)
    );

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == IW'(k)) rd_word = regs[k];
        end
        if (rd_idx == STAT_IDX) begin
            rd_word = hw_status;
        end else if (rd_idx > STAT_IDX) begin
            rd_resp = miss_resp();
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
            pulse   <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
        end else begin
            pulse <= '0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_hit ? RESP_OKAY : miss_resp();
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (wr_idx == IW'(k)) begin
                        regs[k]  <= wr_new;
                        pulse[k] <= 1'b1;
                    end
                end
            end else begin
                if (aw_fire) begin
                    aw_held <= 1'b1;
                    aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
                end
                if (w_fire) begin
                    w_held <= 1'b1;
                    w_data <= S_AXI_WDATA;
                    w_strb <= S_AXI_WSTRB;
                end
            end
            // Commit only happens while bvalid is low, so these never collide.
            if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;

            if (ar_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
                rresp  <= rd_resp;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule
